// File: rtl/mips_avalon_write_buffer.sv
// Posted-write FIFO between the cache controller (upstream Avalon master) and main memory.
// Define WBUF_FWD_EN to let reads hit full-word writes still sitting in the buffer.
module mips_avalon_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                s_address,
  input  logic                       s_write,
  input  logic                       s_read,
  input  logic [31:0]                s_writedata,
  input  logic [3:0]                 s_byteenable,
  output logic                       s_waitrequest,
  output logic [31:0]                s_readdata,
  output logic [31:0]                m_address,
  output logic                       m_write,
  output logic                       m_read,
  output logic [31:0]                m_writedata,
  output logic [3:0]                 m_byteenable,
  input  logic                       m_waitrequest,
  input  logic [31:0]                m_readdata,
  output logic [$clog2(DEPTH):0]     wbuf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t             state, state_nxt;
  logic [31:0]        fifo_addr [DEPTH];
  logic [31:0]        fifo_data [DEPTH];
  logic [3:0]         fifo_be   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, push, pop, rd_req;
  logic               fwd_hit;
  logic [31:0]        fwd_data;

  assign full          = (count == CNT_W'(DEPTH));
  assign rd_req        = s_read && !s_write;
  // A read is only released in RESP; writes are gated purely by space.
  assign s_waitrequest = rst | (s_write ? full : (state != RESP));
  assign push          = s_write && !full;
  assign pop           = (state == WR) && !m_waitrequest;
  assign wbuf_count    = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= s_address;
      fifo_data[wr_ptr] <= s_writedata;
      fifo_be[wr_ptr]   <= s_byteenable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WBUF_FWD_EN
  logic             fwd_full, fwd_partial;
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the last full-word match wins; any partial match forces a drain.
  always_comb begin
    fwd_full    = 1'b0;
    fwd_partial = 1'b0;
    fwd_data    = '0;
    fwd_idx     = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_addr[fwd_idx] == s_address)) begin
        if (fifo_be[fwd_idx] == 4'hF) begin
          fwd_full = 1'b1;
          fwd_data = fifo_data[fwd_idx];
        end else begin
          fwd_partial = 1'b1;
        end
      end
    end
    fwd_hit = rd_req && fwd_full && !fwd_partial;
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fwd_hit)            state_nxt = RESP;
        else if (count != '0)   state_nxt = WR;
        else if (rd_req)        state_nxt = RD;
      end
      WR:      if (!m_waitrequest) state_nxt = IDLE;
      RD:      if (!m_waitrequest) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream bus and read-return registers; held stable while memory stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_address    <= '0;
      m_write      <= 1'b0;
      m_read       <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      s_readdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fwd_hit) begin
            s_readdata <= fwd_data;
          end else if (count != '0) begin
            m_write      <= 1'b1;
            m_address    <= fifo_addr[rd_ptr];
            m_writedata  <= fifo_data[rd_ptr];
            m_byteenable <= fifo_be[rd_ptr];
          end else if (rd_req) begin
            m_read       <= 1'b1;
            m_address    <= s_address;
            m_byteenable <= 4'hF;
          end
        end
        WR: if (!m_waitrequest) m_write <= 1'b0;
        RD: begin
          if (!m_waitrequest) begin
            m_read     <= 1'b0;
            s_readdata <= m_readdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Simultaneous read and write from the master is illegal; the write wins.
  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(s_read && s_write));

endmodule

// File: tb/tb_mips_avalon_write_buffer.sv
// Directed bench for mips_avalon_write_buffer with a behavioural memory slave (READ_DELAY=2).
module tb_mips_avalon_write_buffer;

  localparam int          DEPTH      = 4;
  localparam int          READ_DELAY = 2;
  localparam logic [31:0] BASE       = 32'hBFC00000;

  logic        clk, rst;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_write, s_read, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_write, m_read, m_waitrequest;
  logic [3:0]  m_byteenable;
  logic [$clog2(DEPTH):0] wbuf_count;

  mips_avalon_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_write(s_write), .s_read(s_read),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .m_address(m_address), .m_write(m_write), .m_read(m_read),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .wbuf_count(wbuf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: reads stall READ_DELAY cycles, writes stall one cycle.
  logic [31:0] mem [256];
  int          wait_cnt;
  int          n_wr_done;
  int          n_rd_done;
  bit          loaded;
  logic [7:0]  widx;

  assign widx          = m_address[9:2];
  assign m_readdata    = mem[widx];
  assign m_waitrequest = (m_read || m_write) && (wait_cnt < (m_read ? READ_DELAY : 1));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      if (!loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'hFFFFFF00 | i;
        loaded    <= 1'b1;
        n_wr_done <= 0;
        n_rd_done <= 0;
      end
    end else if (m_read || m_write) begin
      if (!m_waitrequest) begin
        wait_cnt <= 0;
        if (m_write) begin
          for (int b = 0; b < 4; b++)
            if (m_byteenable[b]) mem[widx][8*b +: 8] <= m_writedata[8*b +: 8];
          n_wr_done <= n_wr_done + 1;
        end else begin
          n_rd_done <= n_rd_done + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  n_pushed = 0;
  int  rd_seen = 0;
  int  stall_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timeout observed=stuck expected=progress", tag);
  endtask

  // Called at a falling edge: scoreboards completed writes and checks read ordering.
  task automatic mon();
    wr_t e;
    if (!rst) begin
      if (m_write && !m_waitrequest) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", m_address, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", m_address, e.a);
          chk("wr_data", m_writedata, e.d);
          chk("wr_be", 32'(m_byteenable), 32'(e.be));
        end
      end
      if (m_read) chk("rd_after_writes", 32'(n_pushed - n_wr_done), 32'd0);
      if (m_read && !m_waitrequest) rd_seen++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    bit acc;
    wr_t e;
    n = 0;
    acc = 1'b0;
    s_address = a; s_writedata = d; s_byteenable = be; s_write = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      mon();
      chk("wait_vs_full", 32'(s_waitrequest), 32'((n_pushed - n_wr_done) == DEPTH));
      chk("count", 32'(wbuf_count), 32'(n_pushed - n_wr_done));
      if (s_waitrequest) stall_cycles++;
      acc = !s_waitrequest;
      n++;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      n_pushed++;
      e.a = a; e.d = d; e.be = be;
      exp_q.push_back(e);
    end else begin
      fail_timeout("wr_accept");
    end
    s_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, output int cyc);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    s_address = a; s_read = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      mon();
      acc = !s_waitrequest;
      n++;
      if (acc) chk("rdata", s_readdata, exp);
      @(posedge clk);
      #1;
    end
    cyc = n;
    if (!acc) fail_timeout("rd_accept");
    s_read = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((wbuf_count != '0 || m_write || m_read) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_timeout("drain");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    int r0;
    int w0;
    rst = 1'b0;
    s_address = '0; s_writedata = '0; s_byteenable = '0;
    s_write = 1'b0; s_read = 1'b0;

    // Asynchronous reset asserted mid-cycle, before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_s_wait", 32'(s_waitrequest), 32'd1);
    chk("rst_count", 32'(wbuf_count), 32'd0);
    chk("rst_s_rdata", s_readdata, 32'd0);
    chk("rst_m_addr", m_address, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Read with an empty buffer.
    r0 = rd_seen;
    w0 = n_wr_done;
    rd(BASE + 32'h8, 32'hFFFFFF02, cyc);
    chk("empty_rd_latency", 32'(cyc), 32'd5);
    chk("empty_rd_mread_once", 32'(rd_seen - r0), 32'd1);
    chk("empty_rd_no_write", 32'(n_wr_done - w0), 32'd0);

    // Six back-to-back writes fill the buffer and stall.
    for (int k = 0; k < 6; k++) wr(BASE + 32'h100 + 32'(4 * k), 32'hA5A50000 | k, 4'hF);
    chk("saw_full_stall", 32'(stall_cycles != 0), 32'd1);
    wait_drain();
    for (int k = 0; k < 6; k++) chk("mem_burst", mem[64 + k], 32'hA5A50000 | k);

    // Read-after-write to the same word.
    r0 = rd_seen;
    wr(BASE + 32'h104, 32'hDEADBEEF, 4'hF);
    rd(BASE + 32'h104, 32'hDEADBEEF, cyc);
`ifdef WBUF_FWD_EN
    chk("raw_fwd_no_mread", 32'(rd_seen - r0), 32'd0);
`else
    chk("raw_mread_once", 32'(rd_seen - r0), 32'd1);
`endif
    wait_drain();
    chk("mem_raw", mem[65], 32'hDEADBEEF);

    // Reset while draining three buffered writes.
    wr(BASE + 32'h180, 32'h11111111, 4'hF);
    wr(BASE + 32'h184, 32'h22222222, 4'hF);
    wr(BASE + 32'h188, 32'h33333333, 4'hF);
    w0 = n_wr_done;
    chk("pre_rst_m_write", 32'(m_write), 32'd1);
    chk("pre_rst_count", 32'(wbuf_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_m_write", 32'(m_write), 32'd0);
    chk("mid_rst_m_read", 32'(m_read), 32'd0);
    chk("mid_rst_s_wait", 32'(s_waitrequest), 32'd1);
    chk("mid_rst_count", 32'(wbuf_count), 32'd0);
    exp_q.delete();
    n_pushed = n_wr_done;
    @(posedge clk);
    #1 rst = 1'b0;
    rd(BASE + 32'h180, 32'hFFFFFF60, cyc);
    rd(BASE + 32'h184, 32'hFFFFFF61, cyc);
    rd(BASE + 32'h188, 32'hFFFFFF62, cyc);
    chk("rst_discarded_writes", 32'(n_wr_done - w0), 32'd0);

    // Full-word write followed by a read of the same address.
    r0 = rd_seen;
    wr(BASE + 32'h200, 32'h12345678, 4'hF);
    rd(BASE + 32'h200, 32'h12345678, cyc);
`ifdef WBUF_FWD_EN
    chk("fwd_latency", 32'(cyc), 32'd2);
    chk("fwd_no_mread", 32'(rd_seen - r0), 32'd0);
`else
    chk("nofwd_mread", 32'(rd_seen - r0), 32'd1);
`endif
    wait_drain();

    // Partial-byte write must drain before the read goes downstream.
    r0 = rd_seen;
    wr(BASE + 32'h200, 32'h0000BEEF, 4'b0011);
    rd(BASE + 32'h200, 32'h1234BEEF, cyc);
    chk("partial_mread", 32'(rd_seen - r0), 32'd1);
    wait_drain();
    chk("mem_partial", mem[128], 32'h1234BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
